arbitro_eventos: RTL and testbench
==================================

// Module: arbitro_eventos
// PURPOSE
//  Sits between the debounced button/sensor front-end and the pet state machine.
//  Turns each debounced release (falling edge) into a one-shot request and latches it as pending.
//  Arbitrates the pending requests and hands them out one at a time over a valid/ready handshake.
//  Enforces a minimum gap between delivered events and drops any event the consumer never accepts.
// PARAMETERS
//  N_EVT           5      number of event sources (fixed map below; other values unsupported)
//  GAP_CYCLES      50000  idle cycles after each delivered/dropped event, >=1
//  TIMEOUT_CYCLES  250000 max cycles evt_valid waits for evt_ready before drop, >=1
//  ARB_RR          0      0 = fixed priority (bit0 highest); 1 = round-robin
// PORTS
//  clk         in   1  system clock
//  reset       in   1  synchronous, active-high reset
//  evt_level   in   5  debounced levels: [0]test [1]energia [2]medicina [3]ultrasonido [4]fotocelda
//  enable      in   1  1 = accept new edges; 0 = ignore new edges (pending kept)
//  evt_valid   out  1  event offered to consumer
//  evt_id      out  3  index 0..4 of offered event; stable while evt_valid=1
//  evt_ready   in   1  consumer accepts when evt_valid & evt_ready
//  pending     out  5  latched, not-yet-delivered requests
//  drop_pulse  out  1  1-cycle pulse when an offer times out
//  busy        out  1  1 when state != IDLE
// BEHAVIOUR
//  Reset (sync): state=IDLE; pending=0; prev_level=0; rr_ptr=0; counters=0.
//   Also evt_valid=0, evt_id=0, drop_pulse=0, busy=0.
//  Edge detect: fall[i] = prev_level[i] & ~evt_level[i]; prev_level <= evt_level every cycle.
//   - A source held high through reset yields one event on its first release.
//  Pending latch: pending[i] is set on fall[i] & enable.
//   - A repeat edge on an already-set bit coalesces (no count).
//   - Set and clear in the same cycle: set wins, so the request is retained.
//  FSM states:
//   - IDLE: if pending!=0, register grant index g, evt_id<=g, evt_valid<=1, go to OFFER.
//   - OFFER: evt_valid=1, evt_id held, timeout counter increments each cycle.
//     evt_valid & evt_ready: clear pending[g], evt_valid<=0, load gap counter, go to GAP.
//     Counter == TIMEOUT_CYCLES-1 without ready: clear pending[g], drop_pulse<=1 for 1 cycle,
//     evt_valid<=0, go to GAP.
//     Ready on the timeout cycle counts as an accept; no drop.
//   - GAP: count GAP_CYCLES cycles, then IDLE. Edges keep latching during GAP.
//  Latency: level low first sampled at cycle k -> pending[i]=1 at k+1 -> evt_valid=1 at k+2.
//   This holds when IDLE and the source wins arbitration.
//  Arbitration:
//   - ARB_RR=0: lowest set index wins.
//   - ARB_RR=1: search starts at rr_ptr, wraps 4->0; on accept or drop rr_ptr <= g+1 (4 wraps to 0).
//  enable=0 mid-OFFER: the current offer completes normally; only new edge capture is gated.
//  Reset mid-OFFER or mid-GAP: the event is lost, with no drop_pulse.
//  Counters are sized $clog2(max param)+1 and never wrap.
// STRUCTURE
//  Shared package eventos_pkg:
//   - event index constants EVT_TEST=0, EVT_ENERGIA=1, EVT_MEDICINA=2, EVT_ULTRA=3, EVT_FOTO=4
//   - N_EVT
//   - state encodings ST_IDLE, ST_OFFER, ST_GAP
//  Sub-module detector_flanco #(W): per-bit registered falling-edge detector; sync reset clears prev.
//  Arbiter, pending register, FSM and counters stay in this module.
// TESTING (bench: GAP_CYCLES=4, TIMEOUT_CYCLES=8)
//  1 Fixed priority, single event:
//    energia level 1->0 at cycle 10, evt_ready=1 -> evt_valid=1 with evt_id=1 at cycle 12.
//    pending[1] clears at 13; busy=1 for 1+4 cycles.
//  2 Simultaneous releases, ARB_RR=0:
//    medicina and fotocelda fall in the same cycle -> ids delivered 2 then 4.
//    Second offer starts exactly 4 idle cycles after the first accept.
//  3 Round-robin, ARB_RR=1:
//    all 5 pending, ready tied high -> order 0,1,2,3,4.
//    Re-arm bits 0 and 4 after id 4 is served -> next order 0,4.
//  4 Timeout:
//    evt_ready=0 while id 0 is offered -> evt_valid high 8 cycles, drop_pulse on the next.
//    pending[0]=0; next pending source is offered after the gap.
//  5 Coalesce, set-vs-clear and enable:
//    two ultrasonido edges while pending[3]=1 -> one event.
//    Edge on the accept cycle -> pending[3] stays 1 and a second event follows.
//    Edge with enable=0 -> no pending.
//  6 Reset mid-OFFER:
//    assert reset during evt_valid=1 -> next cycle all outputs 0.
//    No drop_pulse; a level held low produces no spurious event.

Source files
------------

// File: rtl/eventos_pkg.sv
// rtl/eventos_pkg.sv - shared event indices, sizes and FSM encodings for the event arbiter
package eventos_pkg;

  localparam int N_EVT = 5;
  localparam int ID_W  = 3;

  localparam logic [ID_W-1:0] EVT_TEST     = 3'd0;
  localparam logic [ID_W-1:0] EVT_ENERGIA  = 3'd1;
  localparam logic [ID_W-1:0] EVT_MEDICINA = 3'd2;
  localparam logic [ID_W-1:0] EVT_ULTRA    = 3'd3;
  localparam logic [ID_W-1:0] EVT_FOTO     = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Successor of an event index, wrapping the last source back to 0.
  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] i);
    return (i == ID_W'(N_EVT - 1)) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/detector_flanco.sv
// rtl/detector_flanco.sv - per-bit falling-edge detector on registered previous level
module detector_flanco #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] level,
  output logic [W-1:0] fall
);

  logic [W-1:0] prev_level;

  // Clearing prev on reset means a source held high through reset fires on its first release.
  always_ff @(posedge clk) begin
    if (reset) prev_level <= '0;
    else       prev_level <= level;
  end

  assign fall = prev_level & ~level;

endmodule

// File: rtl/arbitro_eventos.sv
// rtl/arbitro_eventos.sv - latches release events, arbitrates them and offers one at a time
module arbitro_eventos
  import eventos_pkg::*;
#(
  parameter int GAP_CYCLES     = 50000,
  parameter int TIMEOUT_CYCLES = 250000,
  parameter int ARB_RR         = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_EVT-1:0] evt_level,
  input  logic             enable,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  input  logic             evt_ready,
  output logic [N_EVT-1:0] pending,
  output logic             drop_pulse,
  output logic             busy
);

  localparam int MAX_P = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CW    = $clog2(MAX_P) + 1;

  state_t           state;
  logic [CW-1:0]    tmo_cnt;
  logic [CW-1:0]    gap_cnt;
  logic [ID_W-1:0]  g;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  base;
  logic [ID_W-1:0]  grant;
  logic             found;
  logic [3:0]       idx;
  logic [N_EVT-1:0] fall;
  logic [N_EVT-1:0] set_mask;
  logic [N_EVT-1:0] clr_mask;
  logic             accept;
  logic             timeout;

  detector_flanco #(.W(N_EVT)) u_det (
    .clk   (clk),
    .reset (reset),
    .level (evt_level),
    .fall  (fall)
  );

  // Ready on the last timeout cycle still counts as an accept.
  assign accept   = (state == ST_OFFER) && evt_ready;
  assign timeout  = (state == ST_OFFER) && !evt_ready && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign set_mask = fall & {N_EVT{enable}};
  assign clr_mask = (accept || timeout) ? (N_EVT'(1) << g) : '0;
  assign busy     = (state != ST_IDLE);
  assign base     = (ARB_RR != 0) ? rr_ptr : '0;

  // Set is OR-ed after the clear so a new edge on the serviced bit is retained.
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~clr_mask) | set_mask;
  end

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_EVT; k++) begin
      idx = {1'b0, base} + 4'(k);
      if (idx >= 4'(N_EVT)) idx = idx - 4'(N_EVT);
      if (!found && pending[idx[ID_W-1:0]]) begin
        grant = idx[ID_W-1:0];
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      g          <= '0;
      rr_ptr     <= '0;
      tmo_cnt    <= '0;
      gap_cnt    <= '0;
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            g         <= grant;
            evt_id    <= grant;
            evt_valid <= 1'b1;
            tmo_cnt   <= '0;
            state     <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (accept || timeout) begin
            evt_valid  <= 1'b0;
            gap_cnt    <= '0;
            rr_ptr     <= next_idx(g);
            drop_pulse <= timeout;
            state      <= ST_GAP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == CW'(GAP_CYCLES - 1)) state   <= ST_IDLE;
          else                                gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_eventos.sv
// tb/tb_arbitro_eventos.sv - directed self-checking bench for arbitro_eventos
module tb_arbitro_eventos;
  import eventos_pkg::*;

  logic       clk;
  logic       reset;
  logic [4:0] evt_level;
  logic       enable;
  logic       evt_ready;

  logic       fp_valid, rr_valid;
  logic [2:0] fp_id, rr_id;
  logic [4:0] fp_pending, rr_pending;
  logic       fp_drop, rr_drop;
  logic       fp_busy, rr_busy;

  int checks = 0;
  int errors = 0;

  arbitro_eventos #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(8), .ARB_RR(0)) dut_fp (
    .clk        (clk),
    .reset      (reset),
    .evt_level  (evt_level),
    .enable     (enable),
    .evt_valid  (fp_valid),
    .evt_id     (fp_id),
    .evt_ready  (evt_ready),
    .pending    (fp_pending),
    .drop_pulse (fp_drop),
    .busy       (fp_busy)
  );

  arbitro_eventos #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(8), .ARB_RR(1)) dut_rr (
    .clk        (clk),
    .reset      (reset),
    .evt_level  (evt_level),
    .enable     (enable),
    .evt_valid  (rr_valid),
    .evt_id     (rr_id),
    .evt_ready  (evt_ready),
    .pending    (rr_pending),
    .drop_pulse (rr_drop),
    .busy       (rr_busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [4:0] lvl, input logic rdy);
    reset = 1'b1; evt_level = lvl; evt_ready = rdy; enable = 1'b1;
    tick; tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic wait_valid(input bit use_rr, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((use_rr ? rr_valid : fp_valid) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; evt_level = 5'b11111; enable = 1'b1; evt_ready = 1'b0;
    tick; tick;
    checks++;
    if ({fp_valid, fp_id, fp_pending, fp_drop, fp_busy} !== 11'b0) begin
      errors++;
      $display("FAIL reset_fp: got %b expected 0", {fp_valid, fp_id, fp_pending, fp_drop, fp_busy});
    end
    checks++;
    if ({rr_valid, rr_id, rr_pending, rr_drop, rr_busy} !== 11'b0) begin
      errors++;
      $display("FAIL reset_rr: got %b expected 0", {rr_valid, rr_id, rr_pending, rr_drop, rr_busy});
    end
    reset = 1'b0;
  endtask

  task automatic test_single;
    int n;
    do_reset(5'b00010, 1'b1);
    evt_level = 5'b00000;
    tick;
    checks++;
    if (fp_pending !== 5'b00010 || fp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pending: pending=%b valid=%b expected 00010/0", fp_pending, fp_valid);
    end
    tick;
    checks++;
    if (fp_valid !== 1'b1 || fp_id !== EVT_ENERGIA || fp_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_offer: valid=%b id=%0d busy=%b expected 1/1/1", fp_valid, fp_id, fp_busy);
    end
    tick;
    checks++;
    if (fp_pending !== 5'b00000 || fp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_clear: pending=%b valid=%b expected 00000/0", fp_pending, fp_valid);
    end
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (fp_busy !== 1'b1) break;
      n++;
      tick;
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL single_busy_len: got %0d cycles expected 5", n);
    end
  endtask

  task automatic test_simultaneous;
    bit ok;
    int lo, gapb;
    do_reset(5'b10100, 1'b1);
    evt_level = 5'b00000;
    wait_valid(1'b0, 10, ok);
    checks++;
    if (!ok || fp_id !== EVT_MEDICINA) begin
      errors++;
      $display("FAIL simul_first: ok=%0d id=%0d expected 1/2", ok, fp_id);
    end
    tick;
    lo = 0; gapb = 0;
    for (int i = 0; i < 20; i++) begin
      if (fp_valid === 1'b1) break;
      lo++;
      if (fp_busy === 1'b1) gapb++;
      tick;
    end
    checks++;
    if (fp_valid !== 1'b1 || fp_id !== EVT_FOTO) begin
      errors++;
      $display("FAIL simul_second: valid=%b id=%0d expected 1/4", fp_valid, fp_id);
    end
    checks++;
    if (gapb != 4 || lo != 5) begin
      errors++;
      $display("FAIL simul_gap: gap=%0d low=%0d expected 4/5", gapb, lo);
    end
    tick;
  endtask

  task automatic test_round_robin;
    bit ok;
    logic [2:0] got;
    logic [2:0] exp_id;
    do_reset(5'b11111, 1'b1);
    evt_level = 5'b00000;
    for (int k = 0; k < 5; k++) begin
      wait_valid(1'b1, 30, ok);
      got = rr_id;
      exp_id = 3'(k);
      checks++;
      if (!ok || got !== exp_id) begin
        errors++;
        $display("FAIL rr_order%0d: ok=%0d id=%0d expected %0d", k, ok, got, exp_id);
      end
      tick;
    end
    evt_level = 5'b10001; tick;
    evt_level = 5'b00000; tick;
    wait_valid(1'b1, 30, ok);
    checks++;
    if (!ok || rr_id !== EVT_TEST) begin
      errors++;
      $display("FAIL rr_rearm0: ok=%0d id=%0d expected 0", ok, rr_id);
    end
    tick;
    // Re-arm 0 while 4 waits: round-robin must now favour 4.
    evt_level = 5'b00001; tick;
    evt_level = 5'b00000; tick;
    wait_valid(1'b1, 30, ok);
    checks++;
    if (!ok || rr_id !== EVT_FOTO) begin
      errors++;
      $display("FAIL rr_rearm4: ok=%0d id=%0d expected 4", ok, rr_id);
    end
    tick;
    wait_valid(1'b1, 30, ok);
    checks++;
    if (!ok || rr_id !== EVT_TEST) begin
      errors++;
      $display("FAIL rr_rearm0b: ok=%0d id=%0d expected 0", ok, rr_id);
    end
    tick;
  endtask

  task automatic test_timeout;
    bit ok;
    int vc;
    do_reset(5'b00011, 1'b0);
    evt_level = 5'b00000;
    wait_valid(1'b0, 10, ok);
    checks++;
    if (!ok || fp_id !== EVT_TEST) begin
      errors++;
      $display("FAIL tmo_offer: ok=%0d id=%0d expected 0", ok, fp_id);
    end
    vc = 0;
    for (int i = 0; i < 20; i++) begin
      if (fp_valid !== 1'b1) break;
      vc++;
      tick;
    end
    checks++;
    if (vc != 8) begin
      errors++;
      $display("FAIL tmo_len: got %0d valid cycles expected 8", vc);
    end
    checks++;
    if (fp_drop !== 1'b1 || fp_pending !== 5'b00010) begin
      errors++;
      $display("FAIL tmo_drop: drop=%b pending=%b expected 1/00010", fp_drop, fp_pending);
    end
    tick;
    checks++;
    if (fp_drop !== 1'b0) begin
      errors++;
      $display("FAIL tmo_pulse_width: drop=%b expected 0", fp_drop);
    end
    evt_ready = 1'b1;
    wait_valid(1'b0, 20, ok);
    checks++;
    if (!ok || fp_id !== EVT_ENERGIA) begin
      errors++;
      $display("FAIL tmo_next: ok=%0d id=%0d expected 1", ok, fp_id);
    end
    tick;
  endtask

  task automatic test_coalesce;
    bit ok;
    int vc;
    do_reset(5'b01000, 1'b0);
    evt_level = 5'b00000;
    wait_valid(1'b0, 10, ok);
    evt_level = 5'b01000; tick;
    evt_level = 5'b00000; tick;
    evt_level = 5'b01000; tick;
    evt_level = 5'b00000; tick;
    checks++;
    if (!ok || fp_valid !== 1'b1 || fp_pending !== 5'b01000) begin
      errors++;
      $display("FAIL coal_hold: ok=%0d valid=%b pending=%b expected 1/1/01000", ok, fp_valid, fp_pending);
    end
    evt_ready = 1'b1; tick;
    evt_ready = 1'b0;
    vc = 0;
    for (int i = 0; i < 15; i++) begin
      if (fp_valid === 1'b1) vc++;
      tick;
    end
    checks++;
    if (vc != 0 || fp_pending !== 5'b00000) begin
      errors++;
      $display("FAIL coal_single: extra=%0d pending=%b expected 0/00000", vc, fp_pending);
    end
    evt_level = 5'b01000; tick;
    evt_level = 5'b00000; tick;
    wait_valid(1'b0, 10, ok);
    evt_level = 5'b01000; tick;
    evt_ready = 1'b1; evt_level = 5'b00000; tick;
    checks++;
    if (!ok || fp_pending !== 5'b01000 || fp_valid !== 1'b0) begin
      errors++;
      $display("FAIL setclr_keep: ok=%0d pending=%b valid=%b expected 1/01000/0", ok, fp_pending, fp_valid);
    end
    wait_valid(1'b0, 20, ok);
    checks++;
    if (!ok || fp_id !== EVT_ULTRA) begin
      errors++;
      $display("FAIL setclr_second: ok=%0d id=%0d expected 3", ok, fp_id);
    end
    tick;
    for (int i = 0; i < 8; i++) tick;
    enable = 1'b0;
    evt_level = 5'b01000; tick;
    evt_level = 5'b00000; tick;
    vc = 0;
    for (int i = 0; i < 10; i++) begin
      if (fp_valid === 1'b1 || fp_pending !== 5'b00000) vc++;
      tick;
    end
    checks++;
    if (vc != 0) begin
      errors++;
      $display("FAIL enable_gate: %0d cycles with activity expected 0", vc);
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_offer;
    bit ok;
    int vc, dc;
    do_reset(5'b00001, 1'b0);
    evt_level = 5'b00000;
    wait_valid(1'b0, 10, ok);
    reset = 1'b1;
    tick;
    checks++;
    if (!ok || {fp_valid, fp_id, fp_pending, fp_drop, fp_busy} !== 11'b0) begin
      errors++;
      $display("FAIL rst_offer: ok=%0d outs=%b expected 1/0", ok, {fp_valid, fp_id, fp_pending, fp_drop, fp_busy});
    end
    reset = 1'b0;
    vc = 0; dc = 0;
    for (int i = 0; i < 20; i++) begin
      if (fp_valid === 1'b1) vc++;
      if (fp_drop === 1'b1) dc++;
      tick;
    end
    checks++;
    if (vc != 0 || dc != 0) begin
      errors++;
      $display("FAIL rst_quiet: valid=%0d drop=%0d expected 0/0", vc, dc);
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; evt_level = '0; enable = 1'b1; evt_ready = 1'b0;
    tick;
    test_reset;
    test_single;
    test_simultaneous;
    test_round_robin;
    test_timeout;
    test_coalesce;
    test_reset_mid_offer;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
